// File: rtl/twos_comp_serial.sv
// Multi-cycle sign unit: pass, negate, abs or -abs of a signed operand,
// processed CHUNK bits per cycle LSB first with a registered ripple carry.
module twos_comp_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4,
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             ovf
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST = CW'(N - 1);
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX  = ~MIN;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CW-1:0]    count_q, count_d;
    logic             inv_q, inv_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic             inv_in;
    logic [31:0]      base;
    logic [CHUNK-1:0] chunk_in;
    logic [CHUNK:0]   sum;

    // Invert decision from the offered operand; only used on accept.
    always_comb begin
        inv_in = 1'b0;
        case (mode)
            2'b00:   inv_in = 1'b0;
            2'b01:   inv_in = 1'b1;
            2'b10:   inv_in = in_data[WIDTH-1];
            default: inv_in = ~in_data[WIDTH-1];
        endcase
    end

    // One chunk of (x ^ inv) + carry; the carry-out ripples into the next cycle.
    always_comb begin
        base     = 32'(count_q) * CHUNK;
        chunk_in = data_q[base +: CHUNK];
        sum      = {1'b0, chunk_in ^ {CHUNK{inv_q}}} + {{CHUNK{1'b0}}, carry_q};
    end

    // Next-state logic: accept in IDLE, ripple in BUSY, present/handshake in DONE.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        out_data_d  = out_data_q;
        count_d     = count_q;
        inv_d       = inv_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    data_d  = in_data;
                    inv_d   = inv_in;
                    carry_d = inv_in;
                    count_d = '0;
                    ovf_d   = (in_data == MIN) && ((mode == 2'b01) || (mode == 2'b10));
                    state_d = StBusy;
                end
            end
            StBusy: begin
                data_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d               = sum[CHUNK];
                count_d               = count_q + CW'(1);
                if (count_q == LAST) begin
                    count_d = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                // First DONE cycle loads the output register (saturating if asked).
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = (SAT && ovf_q) ? MAX : data_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset that aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            data_q      <= '0;
            out_data_q  <= '0;
            count_q     <= '0;
            inv_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
            inv_q       <= inv_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign ovf       = ovf_q && out_valid_q;

endmodule

// File: tb/tb_twos_comp_serial.sv
// Scoreboard bench for twos_comp_serial over five parameter sets.
module tb_twos_comp_serial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        vld  [5];
    logic        ordy [5];
    logic [31:0] din  [5];
    logic [1:0]  md   [5];

    wire irdy0, irdy1, irdy2, irdy3, irdy4;
    wire ov0, ov1, ov2, ov3, ov4;
    wire of0, of1, of2, of3, of4;
    wire [15:0] dout0, dout1, dout4;
    wire [7:0]  dout2;
    wire [31:0] dout3;

    // sel 0: W16 C4 SAT1, 1: W16 C4 SAT0, 2: W8 C1, 3: W32 C8, 4: W16 C16 SAT0
    twos_comp_serial #(.WIDTH(16), .CHUNK(4), .SAT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(vld[0]), .in_ready(irdy0), .in_data(din[0][15:0]),
        .mode(md[0]), .out_valid(ov0), .out_ready(ordy[0]), .out_data(dout0), .ovf(of0));
    twos_comp_serial #(.WIDTH(16), .CHUNK(4), .SAT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(vld[1]), .in_ready(irdy1), .in_data(din[1][15:0]),
        .mode(md[1]), .out_valid(ov1), .out_ready(ordy[1]), .out_data(dout1), .ovf(of1));
    twos_comp_serial #(.WIDTH(8), .CHUNK(1), .SAT(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(vld[2]), .in_ready(irdy2), .in_data(din[2][7:0]),
        .mode(md[2]), .out_valid(ov2), .out_ready(ordy[2]), .out_data(dout2), .ovf(of2));
    twos_comp_serial #(.WIDTH(32), .CHUNK(8), .SAT(1'b1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(vld[3]), .in_ready(irdy3), .in_data(din[3]),
        .mode(md[3]), .out_valid(ov3), .out_ready(ordy[3]), .out_data(dout3), .ovf(of3));
    twos_comp_serial #(.WIDTH(16), .CHUNK(16), .SAT(1'b0)) dut4 (
        .clk(clk), .rst(rst), .in_valid(vld[4]), .in_ready(irdy4), .in_data(din[4][15:0]),
        .mode(md[4]), .out_valid(ov4), .out_ready(ordy[4]), .out_data(dout4), .ovf(of4));

    typedef struct {
        int          sel;
        logic [31:0] data;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    function automatic int wid(input int s);
        case (s)
            2:       return 8;
            3:       return 32;
            default: return 16;
        endcase
    endfunction

    // Number of chunks per operand.
    function automatic int nch(input int s);
        case (s)
            2:       return 8;
            4:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic bit satp(input int s);
        return !(s == 1 || s == 4);
    endfunction

    function automatic logic get_ir(input int s);
        case (s)
            0: return irdy0;
            1: return irdy1;
            2: return irdy2;
            3: return irdy3;
            default: return irdy4;
        endcase
    endfunction

    function automatic logic get_ov(input int s);
        case (s)
            0: return ov0;
            1: return ov1;
            2: return ov2;
            3: return ov3;
            default: return ov4;
        endcase
    endfunction

    function automatic logic get_ovf(input int s);
        case (s)
            0: return of0;
            1: return of1;
            2: return of2;
            3: return of3;
            default: return of4;
        endcase
    endfunction

    function automatic logic [31:0] get_do(input int s);
        case (s)
            0: return {16'b0, dout0};
            1: return {16'b0, dout1};
            2: return {24'b0, dout2};
            3: return dout3;
            default: return {16'b0, dout4};
        endcase
    endfunction

    function automatic logic [31:0] wmask(input int s);
        logic [63:0] m;
        m = (64'd1 << wid(s)) - 64'd1;
        return m[31:0];
    endfunction

    // Behavioural sign model in plain modular arithmetic.
    function automatic exp_t model(input int s, input logic [31:0] d, input logic [1:0] m);
        exp_t        e;
        logic [63:0] mask, x, neg, minv, r;
        logic        sign;
        mask = (64'd1 << wid(s)) - 64'd1;
        x    = {32'b0, d} & mask;
        neg  = (~x + 64'd1) & mask;
        minv = 64'd1 << (wid(s) - 1);
        sign = (x & minv) != 64'd0;
        case (m)
            2'd0:    r = x;
            2'd1:    r = neg;
            2'd2:    r = sign ? neg : x;
            default: r = sign ? x : neg;
        endcase
        e.sel = s;
        e.ovf = (x == minv) && (m == 2'd1 || m == 2'd2);
        if (e.ovf && satp(s)) r = minv - 64'd1;
        e.data = r[31:0];
        return e;
    endfunction

    // One full transaction with optional back-pressure of hold cycles.
    task automatic do_op(input int s, input logic [31:0] d, input logic [1:0] m, input int hold);
        int          lat;
        exp_t        e;
        logic [31:0] od;
        logic        of;
        lat = 0;
        while (!get_ir(s) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (get_ir(s) !== 1'b1) $display("FAIL ready sel%0d: got %b want 1", s, get_ir(s));
        else passed++;
        vld[s] = 1'b1;
        din[s] = d;
        md[s]  = m;
        sb.push_back(model(s, d, m));
        @(negedge clk);
        vld[s] = 1'b0;
        din[s] = $urandom;
        md[s]  = 2'($urandom);
        lat = 0;
        while (!get_ov(s) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat !== nch(s) + 1)
            $display("FAIL latency sel%0d: got %0d want %0d", s, lat, nch(s) + 1);
        else passed++;
        e = sb.pop_front();
        total++;
        if (get_do(s) !== e.data)
            $display("FAIL data sel%0d in=%h mode=%0d: got %h want %h", s, d, m, get_do(s), e.data);
        else passed++;
        total++;
        if (get_ovf(s) !== e.ovf)
            $display("FAIL ovf sel%0d in=%h mode=%0d: got %b want %b", s, d, m, get_ovf(s), e.ovf);
        else passed++;
        od = get_do(s);
        of = get_ovf(s);
        for (int i = 0; i < hold; i++) begin
            vld[s] = (i < hold - 1);
            din[s] = $urandom;
            @(negedge clk);
            total++;
            if (get_do(s) !== od || get_ovf(s) !== of || get_ov(s) !== 1'b1 || get_ir(s) !== 1'b0)
                $display("FAIL hold sel%0d cyc%0d: got data=%h ov=%b ir=%b want data=%h ov=1 ir=0",
                         s, i, get_do(s), get_ov(s), get_ir(s), od);
            else passed++;
        end
        vld[s]  = 1'b0;
        ordy[s] = 1'b1;
        @(negedge clk);
        ordy[s] = 1'b0;
        total++;
        if (get_ov(s) !== 1'b0 || get_ir(s) !== 1'b1)
            $display("FAIL handshake sel%0d: got ov=%b ir=%b want ov=0 ir=1", s, get_ov(s), get_ir(s));
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 5; s++) begin
            vld[s]  = 1'b1;
            ordy[s] = 1'b0;
            din[s]  = 32'h8000_0000;
            md[s]   = 2'd1;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            total++;
            if (get_ir(s) !== 1'b1 || get_ov(s) !== 1'b0 || get_do(s) !== 32'd0 || get_ovf(s) !== 1'b0)
                $display("FAIL reset sel%0d: got ir=%b ov=%b data=%h ovf=%b want 1 0 0 0",
                         s, get_ir(s), get_ov(s), get_do(s), get_ovf(s));
            else passed++;
            vld[s] = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(0, 32'h0005, 2'd1, 0);
        do_op(0, 32'hFF9C, 2'd2, 0);
        do_op(0, 32'h0064, 2'd3, 0);
        do_op(0, 32'h0000, 2'd3, 0);
        do_op(0, 32'h8000, 2'd1, 0);
        do_op(1, 32'h8000, 2'd1, 0);
        do_op(1, 32'h8000, 2'd3, 0);
    endtask

    task automatic test_backpressure();
        do_op(0, 32'hFF9C, 2'd1, 10);
        do_op(3, 32'h8000_0000, 2'd2, 10);
    endtask

    task automatic test_reset_mid_busy();
        int seen;
        vld[0] = 1'b1;
        din[0] = 32'h1234;
        md[0]  = 2'd1;
        @(negedge clk);
        vld[0] = 1'b0;
        @(negedge clk);
        rst    = 1'b1;
        vld[0] = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        vld[0] = 1'b0;
        total++;
        if (irdy0 !== 1'b1 || ov0 !== 1'b0)
            $display("FAIL abort_state: got ir=%b ov=%b want ir=1 ov=0", irdy0, ov0);
        else passed++;
        seen    = 0;
        ordy[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov0 === 1'b1) seen++;
        end
        ordy[0] = 1'b0;
        total++;
        if (seen !== 0) $display("FAIL abort_output: got %0d valid cycles want 0", seen);
        else passed++;
        do_op(0, 32'h0005, 2'd1, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic [1:0]  mods [4];
        exp_t        e;
        int          sent, got, last, cyc;
        vals = '{32'h0005, 32'h8000, 32'hFFFF, 32'h7FFF};
        mods = '{2'd1, 2'd2, 2'd3, 2'd1};
        sent = 0;
        got  = 0;
        last = -1;
        cyc  = 0;
        ordy[0] = 1'b1;
        while (got < 4 && cyc < 200) begin
            if (ov0 === 1'b1) begin
                e = sb.pop_front();
                total++;
                if (get_do(0) !== e.data || of0 !== e.ovf)
                    $display("FAIL b2b_data op%0d: got %h/%b want %h/%b", got, get_do(0), of0,
                             e.data, e.ovf);
                else passed++;
                if (last >= 0) begin
                    total++;
                    if (cyc - last < nch(0) + 2)
                        $display("FAIL b2b_rate: got interval %0d want >= %0d", cyc - last,
                                 nch(0) + 2);
                    else passed++;
                end
                last = cyc;
                got++;
            end
            if (irdy0 === 1'b1 && sent < 4) begin
                vld[0] = 1'b1;
                din[0] = vals[sent];
                md[0]  = mods[sent];
                sb.push_back(model(0, vals[sent], mods[sent]));
                sent++;
            end else begin
                vld[0] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        vld[0]  = 1'b0;
        ordy[0] = 1'b0;
        total++;
        if (got !== 4) $display("FAIL b2b_count: got %0d results want 4", got);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [31:0] corner [5];
        logic [31:0] msk;
        for (int s = 0; s < 5; s++) begin
            msk       = wmask(s);
            corner[0] = 32'd1 << (wid(s) - 1);
            corner[1] = corner[0] - 32'd1;
            corner[2] = 32'd0;
            corner[3] = msk;
            corner[4] = 32'd1;
            for (int c = 0; c < 5; c++)
                for (int m = 0; m < 4; m++)
                    do_op(s, corner[c], 2'(m), 0);
            for (int r = 0; r < 20; r++)
                do_op(s, $urandom & msk, 2'($urandom_range(0, 3)), 0);
        end
    endtask

    initial begin
        for (int s = 0; s < 5; s++) begin
            vld[s]  = 1'b0;
            ordy[s] = 1'b0;
            din[s]  = '0;
            md[s]   = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
